// File: rtl/fp_binop_pipe_pkg.sv
// Shared types and helpers for the f32 binary-op simulation model.
// Operands are widened to double, operated on in double, and rounded back to
// single with round-to-nearest-even. Because a double carries more than twice
// the single-precision mantissa, this reproduces correctly rounded f32
// add/sub/mul results.
package fp_sim_pkg;

    typedef enum logic [2:0] {
        FP_ADD = 3'd0,
        FP_SUB = 3'd1,
        FP_MUL = 3'd2,
        FP_GT  = 3'd3,
        FP_LT  = 3'd4,
        FP_EQ  = 3'd5
    } fp_op_e;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic real f32_to_real(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e11;
        real         r;
        if (x[30:23] == 8'hFF) begin
            d = {x[31], 11'h7FF, x[22:0], 29'b0};
            return $bitstoreal(d);
        end
        if (x[30:23] == 8'h00) begin
            // Zero or subnormal: mantissa * 2^-149, exact in double.
            r = real'(x[22:0]);
            for (int i = 0; i < 149; i++) r = r / 2.0;
            return x[31] ? -r : r;
        end
        e11 = {3'b000, x[30:23]} + 11'd896;
        d   = {x[31], e11, x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        logic [10:0] e11;
        logic [51:0] m52;
        logic [63:0] sig;
        logic [63:0] rem;
        logic [63:0] half;
        logic [30:0] mag;
        int          e;
        int          sh;
        d   = $realtobits(r);
        e11 = d[62:52];
        m52 = d[51:0];
        e   = int'({21'b0, e11}) - 1023;
        if (e11 == 11'h7FF) return (m52 != '0) ? FP_QNAN : {d[63], 31'h7F80_0000};
        if (e11 == 11'h000) return {d[63], 31'b0};
        if (e > 127)        return {d[63], 31'h7F80_0000};
        sig = {11'b0, 1'b1, m52};
        if (e >= -126) begin
            sh  = 29;
            mag = {8'(e + 127), m52[51:29]};
        end else begin
            sh = -97 - e;
            if (sh > 60) return {d[63], 31'b0};
            mag = 31'(sig >> sh);
        end
        rem  = sig & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        // A carry out of the mantissa bumps the exponent, up to infinity.
        if ((rem > half) || ((rem == half) && mag[0])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic logic [31:0] fp_compute(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        real         ra;
        real         rb;
        logic [31:0] res;
        ra = f32_to_real(a);
        rb = f32_to_real(b);
        case (op)
            FP_ADD:  res = real_to_f32(ra + rb);
            FP_SUB:  res = real_to_f32(ra - rb);
            FP_MUL:  res = real_to_f32(ra * rb);
            // Real compares are false against NaN and treat +0 and -0 as equal.
            FP_GT:   res = {31'b0, ra > rb};
            FP_LT:   res = {31'b0, ra < rb};
            FP_EQ:   res = {31'b0, ra == rb};
            default: res = FP_QNAN;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fp_binop_pipe_if.sv
// AXI-stream operand/result bundle for the f32 binary-op model.
interface fp_binop_pipe_if;
    import fp_sim_pkg::*;

    logic        s_axis_a_tvalid;
    logic        s_axis_a_tready;
    logic [31:0] s_axis_a_tdata;
    logic        s_axis_b_tvalid;
    logic        s_axis_b_tready;
    logic [31:0] s_axis_b_tdata;
    logic [2:0]  s_axis_op_tdata;
    logic        m_axis_result_tvalid;
    logic        m_axis_result_tready;
    logic [31:0] m_axis_result_tdata;
    logic        op_err;

    modport master (
        output s_axis_a_tvalid, s_axis_a_tdata,
        output s_axis_b_tvalid, s_axis_b_tdata,
        output s_axis_op_tdata, m_axis_result_tready,
        input  s_axis_a_tready, s_axis_b_tready,
        input  m_axis_result_tvalid, m_axis_result_tdata, op_err
    );

    modport slave (
        input  s_axis_a_tvalid, s_axis_a_tdata,
        input  s_axis_b_tvalid, s_axis_b_tdata,
        input  s_axis_op_tdata, m_axis_result_tready,
        output s_axis_a_tready, s_axis_b_tready,
        output m_axis_result_tvalid, m_axis_result_tdata, op_err
    );

endinterface

// File: rtl/fp_binop_pipe_valid_pipe.sv
// Fixed-latency valid+data delay line; reset clears only the valid bits.
module fp_valid_pipe #(
    parameter int LATENCY = 12,
    parameter int WIDTH   = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // Shift the valid bits, dropping everything in flight on reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
        end
    end

    // Data follows the valids; its content is don't-care when the valid is low.
    always_ff @(posedge aclk) begin
        data_q[0] <= data_i;
        for (int i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/fp_binop_pipe.sv
// Runtime-selectable f32 binary op with fixed latency and a credit-limited
// first-word-fall-through result FIFO. Occupancy counts every accepted
// transaction until its result leaves, so a pipeline result always finds a
// free FIFO slot and the pipeline itself never stalls.
module fp_binop_pipe
    import fp_sim_pkg::*;
#(
    parameter int LATENCY    = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    fp_binop_pipe_if.slave bus
);

    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);

    logic          accept_en;
    logic          fire;
    logic          pop;
    logic          push;
    logic [31:0]   result_c;
    logic [31:0]   pipe_data;
    logic [CW-1:0] occ_q;
    logic [CW-1:0] occ_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic          op_err_q;
    logic          m_valid;

    assign accept_en = aresetn && (occ_q < DEPTH_C);
    assign fire      = bus.s_axis_a_tvalid && bus.s_axis_b_tvalid && accept_en;
    assign m_valid   = aresetn && (cnt_q != '0);
    assign pop       = m_valid && bus.m_axis_result_tready;
    assign result_c  = fp_compute(bus.s_axis_op_tdata, bus.s_axis_a_tdata, bus.s_axis_b_tdata);

    fp_valid_pipe #(
        .LATENCY (LATENCY),
        .WIDTH   (32)
    ) u_pipe (
        .aclk    (aclk),
        .aresetn (aresetn),
        .valid_i (fire),
        .data_i  (result_c),
        .valid_o (push),
        .data_o  (pipe_data)
    );

    // Next occupancy and FIFO count; a simultaneous inc and dec cancel.
    always_comb begin
        occ_d = occ_q;
        cnt_d = cnt_q;
        if (fire && !pop)      occ_d = occ_q + CW'(1);
        else if (!fire && pop) occ_d = occ_q - CW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    // Counters, wrapping pointers and the sticky reserved-opcode flag.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            op_err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            if (fire && op_is_reserved(bus.s_axis_op_tdata)) op_err_q <= 1'b1;
        end
    end

    // FIFO storage; entries are only meaningful between the pointers.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= pipe_data;
    end

    assign bus.s_axis_a_tready      = accept_en;
    assign bus.s_axis_b_tready      = accept_en;
    assign bus.m_axis_result_tvalid = m_valid;
    assign bus.m_axis_result_tdata  = m_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign bus.op_err               = op_err_q;

endmodule

// File: tb/tb_fp_binop_pipe.sv
// Directed bench for fp_binop_pipe: single-op vector table plus streaming,
// backpressure, lone-valid and mid-stream reset sequences.
module tb_fp_binop_pipe;

    localparam int LAT   = 12;
    localparam int DEPTH = 16;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    fp_binop_pipe_if bus ();

    fp_binop_pipe #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.s_axis_a_tvalid = v;
        bus.s_axis_b_tvalid = v;
        bus.s_axis_op_tdata = op;
        bus.s_axis_a_tdata  = a;
        bus.s_axis_b_tdata  = b;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.m_axis_result_tvalid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    vec_t        vecs [13];
    int          cyc;
    int          acc;
    int          rcv;
    int          seen;
    logic [31:0] head;
    logic [31:0] exp3 [3];

    initial begin
        vecs[0]  = '{3'd0, 32'h3FC00000, 32'h40100000, 32'h40700000}; // 1.5+2.25
        vecs[1]  = '{3'd2, 32'h40000000, 32'h40400000, 32'h40C00000}; // 2*3
        vecs[2]  = '{3'd1, 32'h40A00000, 32'h3F800000, 32'h40800000}; // 5-1
        vecs[3]  = '{3'd3, 32'h40400000, 32'h40000000, 32'h00000001}; // 3>2
        vecs[4]  = '{3'd3, 32'h3F800000, 32'h40000000, 32'h00000000}; // 1>2
        vecs[5]  = '{3'd4, 32'h7FC00000, 32'h3F800000, 32'h00000000}; // NaN<1
        vecs[6]  = '{3'd5, 32'h80000000, 32'h00000000, 32'h00000001}; // -0==+0
        vecs[7]  = '{3'd5, 32'h7FC00000, 32'h7FC00000, 32'h00000000}; // NaN==NaN
        vecs[8]  = '{3'd1, 32'h3F800000, 32'h3F800000, 32'h00000000}; // 1-1=+0
        vecs[9]  = '{3'd2, 32'h7F000000, 32'h40000000, 32'h7F800000}; // overflow
        vecs[10] = '{3'd0, 32'h3F800000, 32'h33800000, 32'h3F800000}; // tie, even
        vecs[11] = '{3'd0, 32'h3F800001, 32'h33800000, 32'h3F800002}; // tie, odd
        vecs[12] = '{3'd2, 32'h00800000, 32'h3F000000, 32'h00400000}; // subnormal

        aresetn = 1'b0;
        bus.m_axis_result_tready = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        check("reset_a_tready", {31'b0, bus.s_axis_a_tready}, 32'h0);
        check("reset_b_tready", {31'b0, bus.s_axis_b_tready}, 32'h0);
        check("reset_tvalid", {31'b0, bus.m_axis_result_tvalid}, 32'h0);
        check("reset_tdata", bus.m_axis_result_tdata, 32'h0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("post_reset_op_err", {31'b0, bus.op_err}, 32'h0);
        check("post_reset_tready", {31'b0, bus.s_axis_a_tready}, 32'h1);

        // Single transactions from the table, with latency measured each time.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            drive(1'b0, 3'd0, 32'h0, 32'h0);
            wait_valid(cyc);
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(LAT));
            check($sformatf("vec%0d_data", i), bus.m_axis_result_tdata, vecs[i].exp);
            check($sformatf("vec%0d_op_err", i), {31'b0, bus.op_err}, 32'h0);
            tick();
            check($sformatf("vec%0d_drained", i), {31'b0, bus.m_axis_result_tvalid}, 32'h0);
        end

        // Back-to-back stream produces back-to-back results in order.
        exp3[0] = 32'h40C00000;
        exp3[1] = 32'h40800000;
        exp3[2] = 32'h00000001;
        drive(1'b1, 3'd2, 32'h40000000, 32'h40400000);
        tick();
        drive(1'b1, 3'd1, 32'h40A00000, 32'h3F800000);
        tick();
        drive(1'b1, 3'd3, 32'h40400000, 32'h40000000);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        wait_valid(cyc);
        check("stream_latency", 32'(cyc), 32'(LAT - 2));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream%0d_valid", i), {31'b0, bus.m_axis_result_tvalid}, 32'h1);
            check($sformatf("stream%0d_data", i), bus.m_axis_result_tdata, exp3[i]);
            tick();
        end
        check("stream_end", {31'b0, bus.m_axis_result_tvalid}, 32'h0);

        // Reserved opcode yields quiet NaN and sets the sticky error.
        drive(1'b1, 3'd6, 32'h3F800000, 32'h3F800000);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        wait_valid(cyc);
        check("rsvd_data", bus.m_axis_result_tdata, 32'h7FC00000);
        check("rsvd_op_err", {31'b0, bus.op_err}, 32'h1);
        tick();

        // A lone operand valid must not be consumed.
        seen = 0;
        bus.s_axis_a_tvalid = 1'b1;
        bus.s_axis_a_tdata  = 32'h3F800000;
        bus.s_axis_b_tdata  = 32'h40000000;
        bus.s_axis_op_tdata = 3'd0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lone%0d_tready", i), {31'b0, bus.s_axis_b_tready}, 32'h1);
            tick();
        end
        bus.s_axis_b_tvalid = 1'b1;
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3 * LAT; i++) begin
            if (bus.m_axis_result_tvalid) begin
                seen++;
                check("lone_data", bus.m_axis_result_tdata, 32'h40400000);
            end
            tick();
        end
        check("lone_result_count", 32'(seen), 32'd1);

        // Backpressure: FIFO_DEPTH credits, head holds, then drain all in order.
        bus.m_axis_result_tready = 1'b0;
        acc = 0;
        rcv = 0;
        for (int i = 0; i < 40; i++) begin
            drive(acc < 20, 3'd0, 32'h3F800000 + 32'(acc), 32'h00000000);
            if (acc < 20 && bus.s_axis_a_tready) acc++;
            tick();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        check("bp_accepted", 32'(acc), 32'(DEPTH));
        check("bp_a_tready_low", {31'b0, bus.s_axis_a_tready}, 32'h0);
        check("bp_b_tready_low", {31'b0, bus.s_axis_b_tready}, 32'h0);
        check("bp_tvalid", {31'b0, bus.m_axis_result_tvalid}, 32'h1);
        head = bus.m_axis_result_tdata;
        check("bp_head", head, 32'h3F800000);
        tick();
        tick();
        check("bp_head_stable", bus.m_axis_result_tdata, 32'h3F800000);
        bus.m_axis_result_tready = 1'b1;
        for (int i = 0; i < 200 && rcv < 20; i++) begin
            if (bus.m_axis_result_tvalid) begin
                check($sformatf("bp_out%0d", rcv), bus.m_axis_result_tdata, 32'h3F800000 + 32'(rcv));
                rcv++;
            end
            drive(acc < 20, 3'd0, 32'h3F800000 + 32'(acc), 32'h00000000);
            if (acc < 20 && bus.s_axis_a_tready) acc++;
            tick();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        check("bp_total_accepted", 32'(acc), 32'd20);
        check("bp_total_received", 32'(rcv), 32'd20);
        check("op_err_held", {31'b0, bus.op_err}, 32'h1);

        // Reset with eight results in flight discards all of them.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd0, 32'h40000000, 32'h3F800000);
            tick();
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        tick();
        tick();
        aresetn = 1'b0;
        #1;
        check("midrst_tready", {31'b0, bus.s_axis_a_tready}, 32'h0);
        check("midrst_tvalid", {31'b0, bus.m_axis_result_tvalid}, 32'h0);
        check("midrst_tdata", bus.m_axis_result_tdata, 32'h0);
        tick();
        aresetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            if (bus.m_axis_result_tvalid) seen++;
            tick();
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        check("midrst_op_err", {31'b0, bus.op_err}, 32'h0);
        drive(1'b1, 3'd0, 32'h3FC00000, 32'h40100000);
        tick();
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        wait_valid(cyc);
        check("after_rst_latency", 32'(cyc), 32'(LAT));
        check("after_rst_data", bus.m_axis_result_tdata, 32'h40700000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
